adc_frame_capture: RTL and testbench

- Upstream stage of the AXI-Stream packet controller.
- Collects 32-bit ADC samples, one per `adc_dv` strobe, into a 256-word frame register.
- Presents the frame as `ADC_data[8191:0]` with `valid` held high until the downstream controller signals the frame is sent.
- Counts samples dropped while the frame is held, so software can detect overrun.

---
 rtl/adc_frame_capture.sv | 102 ++++++++++
 tb/tb_adc_frame_capture.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_capture.sv
// Captures one frame of NWORDS 32-bit ADC samples and holds it until the consumer reports it sent.
// Optional FRAME_TAG_EN: word 0 carries a frame sequence number, and samples fill words 1..NWORDS-1.
module adc_frame_capture #(
  parameter int NWORDS = 256,
  parameter int OVR_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic [31:0]            adc_din,
  input  logic                   adc_dv,
  input  logic                   frame_done,
  output logic [32*NWORDS-1:0]   ADC_data,
  output logic                   valid,
  output logic [OVR_W-1:0]       ovr_cnt,
  output logic                   ovr_flag,
  output logic                   busy
);

  localparam int PW = $clog2(NWORDS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
`ifdef FRAME_TAG_EN
  localparam logic [PW-1:0] FIRST = PW'(1);
`else
  localparam logic [PW-1:0] FIRST = '0;
`endif

  logic [1:0]            r_state;
  logic [PW-1:0]         r_wr_ptr;
  logic [32*NWORDS-1:0]  r_data;
  logic [OVR_W-1:0]      r_ovr;
  logic                  r_flag;
`ifdef FRAME_TAG_EN
  logic [31:0]           r_seq;
`endif

  logic w_last;
  assign w_last = (r_wr_ptr == PW'(NWORDS-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_data   <= '0;
      r_ovr    <= '0;
      r_flag   <= 1'b0;
`ifdef FRAME_TAG_EN
      r_seq    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_state  <= S_FILL;
            r_wr_ptr <= FIRST;
          end
        end
        S_FILL: begin
          // abort wins over a coincident strobe; the partial frame is simply abandoned
          if (!arm) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
          end else if (adc_dv) begin
            r_data[{r_wr_ptr, 5'd0} +: 32] <= adc_din;
            if (w_last) begin
              r_state <= S_FULL;
`ifdef FRAME_TAG_EN
              r_data[31:0] <= r_seq;
              r_seq        <= r_seq + 32'd1;
`endif
            end else begin
              r_wr_ptr <= r_wr_ptr + PW'(1);
            end
          end
        end
        S_FULL: begin
          if (adc_dv) begin
            if (r_ovr != '1) r_ovr <= r_ovr + OVR_W'(1);
            r_flag <= 1'b1;
          end
          if (frame_done) begin
            r_state  <= arm ? S_FILL : S_IDLE;
            r_wr_ptr <= arm ? FIRST : '0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_wr_ptr <= '0;
        end
      endcase
    end
  end

  assign ADC_data = r_data;
  assign valid    = (r_state == S_FULL);
  assign busy     = (r_state != S_IDLE);
  assign ovr_cnt  = r_ovr;
  assign ovr_flag = r_flag;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Self-checking bench for adc_frame_capture: scoreboard queue of expected frame words,
// a table of frame/overrun records, and hand sequences for abort, reset and same-cycle cases.
module tb_adc_frame_capture;
  localparam int NW = 256;
  localparam int OW = 4;
`ifdef FRAME_TAG_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NS = NW - FIRST;

  logic              clk = 1'b0;
  logic              rst, arm, adc_dv, frame_done;
  logic [31:0]       adc_din;
  logic [32*NW-1:0]  ADC_data;
  logic              valid, ovr_flag, busy;
  logic [OW-1:0]     ovr_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [31:0] exp_frame [NW];
  logic [31:0] exp_seq;

  typedef struct {
    logic [31:0] base;
    int          drops;
    logic [31:0] exp_ovr;
    logic        exp_flag;
  } rec_t;
  rec_t tbl [4];

  adc_frame_capture #(.NWORDS(NW), .OVR_W(OW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .adc_din(adc_din), .adc_dv(adc_dv),
    .frame_done(frame_done), .ADC_data(ADC_data), .valid(valid),
    .ovr_cnt(ovr_cnt), .ovr_flag(ovr_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_samples(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      adc_dv = 1'b1; adc_din = base + i;
      tick();
    end
    adc_dv = 1'b0;
  endtask

  // full frame; expected words go to the scoreboard as they are driven
  task automatic send_frame(input logic [31:0] base);
`ifdef FRAME_TAG_EN
    q.push_back(exp_seq);
    exp_seq = exp_seq + 32'd1;
`endif
    for (int i = 0; i < NS; i++) begin
      adc_dv = 1'b1; adc_din = base + i;
      q.push_back(base + i);
      if (i == NS-1) check("valid_before_last", {31'd0, valid}, 32'd0);
      tick();
    end
    adc_dv = 1'b0;
  endtask

  task automatic compare_frame(input string nm);
    int n;
    n = 0;
    while (!valid && n < 20) begin tick(); n++; end
    check({nm, "_valid"}, {31'd0, valid}, 32'd1);
    check({nm, "_latency"}, n, 0);
    for (int i = 0; i < NW; i++) begin
      exp_frame[i] = (q.size() > 0) ? q.pop_front() : 32'hx;
      check($sformatf("%s_w%0d", nm, i), ADC_data[32*i +: 32], exp_frame[i]);
    end
  endtask

  task automatic recheck(input string nm);
    for (int i = 0; i < NW; i++)
      check($sformatf("%s_w%0d", nm, i), ADC_data[32*i +: 32], exp_frame[i]);
  endtask

  initial begin
    tbl[0] = '{base: 32'd3000, drops: 0,  exp_ovr: 32'd0,  exp_flag: 1'b0};
    tbl[1] = '{base: 32'd4000, drops: 7,  exp_ovr: 32'd7,  exp_flag: 1'b1};
    tbl[2] = '{base: 32'd6000, drops: 10, exp_ovr: 32'd15, exp_flag: 1'b1};
    tbl[3] = '{base: 32'hFFFF_FF80, drops: 2, exp_ovr: 32'd15, exp_flag: 1'b1};

    rst = 1'b0; arm = 1'b0; adc_dv = 1'b0; frame_done = 1'b0; adc_din = '0;
    exp_seq = '0;
    tick(); tick();
    check("rst_data", {31'd0, |ADC_data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ovr", {28'd0, ovr_cnt}, 32'd0);
    check("rst_flag", {31'd0, ovr_flag}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    tick();

    // frame_done in IDLE is ignored
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    check("idle_done_busy", {31'd0, busy}, 32'd0);

    // strobe in the arming cycle must not be captured
    arm = 1'b1; adc_dv = 1'b1; adc_din = 32'hDEAD_BEEF;
    tick();
    adc_dv = 1'b0;
    check("arm_busy", {31'd0, busy}, 32'd1);
    send_frame(32'd0);
    compare_frame("f0");
    check("f0_ovr", {28'd0, ovr_cnt}, 32'd0);

    // dropped samples while held, arm low does not release the frame
    arm = 1'b0;
    send_samples(32'h5555_0000, 5);
    check("hold_valid", {31'd0, valid}, 32'd1);
    check("hold_ovr", {28'd0, ovr_cnt}, 32'd5);
    check("hold_flag", {31'd0, ovr_flag}, 32'd1);
    recheck("hold");
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    check("done_valid", {31'd0, valid}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd0);

    // frame_done together with a strobe: strobe counted, next frame back-to-back
    arm = 1'b1; tick();
    send_frame(32'd100);
    compare_frame("f1");
    adc_dv = 1'b1; frame_done = 1'b1; adc_din = 32'h0000_0BAD;
    tick();
    adc_dv = 1'b0; frame_done = 1'b0;
    check("same_ovr", {28'd0, ovr_cnt}, 32'd6);
    check("same_valid", {31'd0, valid}, 32'd0);
    check("same_busy", {31'd0, busy}, 32'd1);
    send_frame(32'd2000);
    compare_frame("f2");

    // abort after 100 samples, then a clean frame
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    send_samples(32'd7000, 100);
    arm = 1'b0; tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, valid}, 32'd0);
    arm = 1'b1; tick();
    send_frame(32'd1000);
    compare_frame("f3");

    // asynchronous reset in the middle of a frame
    frame_done = 1'b1; arm = 1'b0; tick(); frame_done = 1'b0;
    arm = 1'b1; tick();
    send_samples(32'd8000, 128);
    #2 rst = 1'b0;
    #1;
    check("mrst_data", {31'd0, |ADC_data}, 32'd0);
    check("mrst_valid", {31'd0, valid}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_ovr", {28'd0, ovr_cnt}, 32'd0);
    check("mrst_flag", {31'd0, ovr_flag}, 32'd0);
    q.delete();
    exp_seq = '0;
    tick();
    rst = 1'b1;
    tick();
    arm = 1'b1; tick();

    // table: frames with overrun bursts, counter saturates at all-ones
    for (int r = 0; r < 4; r++) begin
      send_frame(tbl[r].base);
      compare_frame($sformatf("t%0d", r));
      send_samples(32'hAAAA_0000, tbl[r].drops);
      check($sformatf("t%0d_ovr", r), {28'd0, ovr_cnt}, tbl[r].exp_ovr);
      check($sformatf("t%0d_flag", r), {31'd0, ovr_flag}, {31'd0, tbl[r].exp_flag});
      frame_done = 1'b1; tick(); frame_done = 1'b0;
      check($sformatf("t%0d_done_valid", r), {31'd0, valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
